// File: rtl/log_ram_capture.sv
// Capture stage for the debug logging path: records a burst of samples into on-chip RAM,
// then plays the RAM back one word per read request once the buffer is full.
module log_ram_capture #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 10
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    input  logic               i_log_start,
    input  logic               i_read_next,
    output logic [NB_DATA-1:0] o_log_data_from_ram,
    output logic               o_log_ram_full,
    output logic               o_busy
);

    localparam int                 DEPTH    = 2 ** NB_ADDR;
    localparam logic [NB_ADDR-1:0] ADDR_MAX = {NB_ADDR{1'b1}};
    localparam logic [NB_ADDR-1:0] ADDR_ONE = NB_ADDR'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_start_prev;
    logic               r_read_prev;
    logic               w_start_evt;
    logic               w_read_evt;
    logic [NB_ADDR-1:0] r_wr_addr;
    logic [NB_ADDR-1:0] w_wr_addr_next;
    logic [NB_ADDR-1:0] r_rd_addr;
    logic [NB_ADDR-1:0] w_rd_addr_next;
    logic               w_mem_we;
    logic [NB_DATA-1:0] r_rd_data;

    // No reset on the array so the tools can map it onto RAM primitives.
    logic [NB_DATA-1:0] r_mem [DEPTH];

    // VIO controls are slow levels; only their 0->1 transitions are events.
    assign w_start_evt = i_log_start & ~r_start_prev;
    assign w_read_evt  = i_read_next & ~r_read_prev;

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_start_prev <= 1'b0;
            r_read_prev  <= 1'b0;
        end else begin
            r_start_prev <= i_log_start;
            r_read_prev  <= i_read_next;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_addr <= w_wr_addr_next;
            r_rd_addr <= w_rd_addr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_wr_addr_next = r_wr_addr;
        w_rd_addr_next = r_rd_addr;
        w_mem_we       = 1'b0;
        o_busy         = 1'b0;
        o_log_ram_full = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_next   = ST_CAPTURE;
                    w_wr_addr_next = '0;
                end
            end
            ST_CAPTURE: begin
                o_busy = 1'b1;
                if (i_valid) begin
                    w_mem_we       = 1'b1;
                    w_wr_addr_next = r_wr_addr + ADDR_ONE;
                    // Last word written: address wraps, playback starts from word 0.
                    if (r_wr_addr == ADDR_MAX) begin
                        w_state_next   = ST_FULL;
                        w_rd_addr_next = '0;
                    end
                end
            end
            ST_FULL: begin
                o_log_ram_full = 1'b1;
                // Re-arm takes priority; a coincident read request is dropped.
                if (w_start_evt) begin
                    w_state_next   = ST_CAPTURE;
                    w_wr_addr_next = '0;
                    w_rd_addr_next = '0;
                end else if (w_read_evt) begin
                    w_rd_addr_next = r_rd_addr + ADDR_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[r_wr_addr] <= i_data;
        end
    end

    // Playback register only refreshes in FULL, so it holds its last word otherwise.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_data <= '0;
        end else if (r_state == ST_FULL) begin
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    assign o_log_data_from_ram = r_rd_data;

endmodule
